// File: rtl/dac_wave_sequencer.sv
// dac_wave_sequencer: sample-rate phase accumulator feeding one DAC code per tick to the I2C engine
module dac_wave_sequencer #(
  parameter int SAMPLE_DIV = 6000,
  parameter int PHASE_W    = 16
) (
  input  logic               sys_clk_12m,
  input  logic               rst,
  input  logic               enable,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic [1:0]         wave_sel,
  input  logic [7:0]         dc_level,
  output logic [7:0]         wave_rom_address,
  input  logic [7:0]         wave_rom_data,
  output logic [7:0]         dac_data,
  output logic               dac_req,
  input  logic               i2c_done,
  output logic               busy,
  output logic [7:0]         overrun_cnt,
  output logic [15:0]        sample_cnt
);
  typedef enum logic [2:0] {IDLE, ROM1, ROM2, REQ, WAIT_DONE} state_t;
  localparam logic [15:0] DIV_MAX = 16'(SAMPLE_DIV - 1);
  state_t state, state_n;
  logic [15:0] div_cnt;
  logic [PHASE_W-1:0] phase;
  logic [1:0] sel;
  logic [7:0] src;
  logic tick, accept, drop;
  assign tick    = enable && div_cnt == DIV_MAX;
  assign accept  = tick && (state == IDLE || (state == WAIT_DONE && i2c_done));
  assign drop    = tick && !accept;
  assign dac_req = state == REQ;
  assign busy    = state != IDLE;
  always_ff @(posedge sys_clk_12m)
    state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = accept ? ROM1 : IDLE;
      ROM1:      state_n = ROM2;
      ROM2:      state_n = REQ;
      REQ:       state_n = WAIT_DONE;
      WAIT_DONE: state_n = accept ? ROM1 : i2c_done ? IDLE : WAIT_DONE;
      default:   state_n = IDLE;
    endcase
  end
  // Dropped ticks still advance the phase so the output frequency is preserved
  always_ff @(posedge sys_clk_12m) begin
    if (rst) begin
      div_cnt          <= '0;
      phase            <= '0;
      sel              <= '0;
      src              <= '0;
      wave_rom_address <= '0;
      dac_data         <= '0;
      overrun_cnt      <= '0;
      sample_cnt       <= '0;
    end else begin
      div_cnt <= (!enable || tick) ? '0 : div_cnt + 16'd1;
      if (tick) phase <= phase + phase_inc;
      if (accept) begin
        wave_rom_address <= phase[PHASE_W-1 -: 8];
        sel              <= wave_sel;
        src              <= wave_sel == 2'd1 ? {8{~phase[PHASE_W-1]}} :
                            wave_sel == 2'd2 ? phase[PHASE_W-1 -: 8] : dc_level;
      end
      if (state == ROM2) dac_data <= sel == 2'd0 ? wave_rom_data : src;
      if (drop && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
      if (state == WAIT_DONE && i2c_done) sample_cnt <= sample_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_dac_wave_sequencer.sv
// tb_dac_wave_sequencer: directed checks of tick timing, sources, overrun and handshake
module tb_dac_wave_sequencer;
  logic clk, rst, enable, i2c_done, dac_req, busy;
  logic [15:0] phase_inc, sample_cnt;
  logic [1:0] wave_sel;
  logic [7:0] dc_level, rom_addr, rom_q, dac_data, overrun_cnt;
  int tests = 0, fails = 0, nreq;

  dac_wave_sequencer #(.SAMPLE_DIV(16), .PHASE_W(16)) dut (
    .sys_clk_12m(clk), .rst(rst), .enable(enable), .phase_inc(phase_inc),
    .wave_sel(wave_sel), .dc_level(dc_level), .wave_rom_address(rom_addr),
    .wave_rom_data(rom_q), .dac_data(dac_data), .dac_req(dac_req),
    .i2c_done(i2c_done), .busy(busy), .overrun_cnt(overrun_cnt), .sample_cnt(sample_cnt));

  initial clk = 0;
  always #5 clk = ~clk;
  always_ff @(posedge clk) rom_q <= rom_addr ^ 8'h5A;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_done();
    i2c_done = 1;
    step(1);
    i2c_done = 0;
  endtask

  // reset, then land on the first dac_req (tick at cycle 15, req at cycle 18)
  task automatic start(input logic [1:0] s, input logic [15:0] inc);
    rst = 1;
    step(2);
    wave_sel = s;
    phase_inc = inc;
    enable = 1;
    i2c_done = 0;
    rst = 0;
    step(18);
    chk("start_req", dac_req, 1);
    chk("start_ovr", overrun_cnt, 0);
  endtask

  // done 5 cycles after req; next req exactly 16 cycles after the previous one
  task automatic next_sample(input string tag, input logic [7:0] data, input logic [15:0] cnt);
    step(5);
    pulse_done();
    chk({tag, "_idle"}, busy, 0);
    step(9);
    chk({tag, "_early"}, dac_req, 0);
    step(1);
    chk({tag, "_req"}, dac_req, 1);
    chk({tag, "_data"}, dac_data, data);
    chk({tag, "_cnt"}, sample_cnt, cnt);
  endtask

  initial begin
    rst = 1;
    i2c_done = 0;
    enable = 1'($urandom);
    wave_sel = 2'($urandom);
    phase_inc = 16'($urandom);
    dc_level = 8'($urandom);
    step(3);
    chk("rst_addr", rom_addr, 0);
    chk("rst_data", dac_data, 0);
    chk("rst_req", dac_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun_cnt, 0);
    chk("rst_cnt", sample_cnt, 0);
    enable = 1;
    wave_sel = 2;
    phase_inc = 16'h0100;
    rst = 0;
    nreq = 0;
    for (int i = 0; i < 17; i++) begin
      step(1);
      if (dac_req) nreq++;
    end
    chk("rst_noreq", 16'(nreq), 0);
    step(1);
    chk("saw0_req", dac_req, 1);
    chk("saw0_data", dac_data, 8'h00);
    chk("saw0_busy", busy, 1);
    next_sample("saw1", 8'h01, 1);
    next_sample("saw2", 8'h02, 2);
    next_sample("saw3", 8'h03, 3);
    chk("saw_ovr", overrun_cnt, 0);

    start(1, 16'h8000);
    chk("sq0_data", dac_data, 8'hFF);
    next_sample("sq1", 8'h00, 1);
    next_sample("sq2", 8'hFF, 2);
    next_sample("sq3", 8'h00, 3);

    start(0, 16'h0400);
    chk("rom0_data", dac_data, 8'h5A);
    chk("rom0_addr", rom_addr, 8'h00);
    next_sample("rom1", 8'h5E, 1);
    chk("rom1_addr", rom_addr, 8'h04);
    next_sample("rom2", 8'h52, 2);
    chk("rom2_addr", rom_addr, 8'h08);

    dc_level = 8'h3C;
    start(3, 16'h1234);
    chk("dc_data", dac_data, 8'h3C);

    // no done: every later tick is dropped, phase still advances
    start(2, 16'h0100);
    step(14);
    chk("ovr_first", overrun_cnt, 1);
    chk("ovr_busy", busy, 1);
    nreq = 0;
    for (int i = 0; i < 4064; i++) begin
      step(1);
      if (dac_req) nreq++;
    end
    chk("ovr_255", overrun_cnt, 8'hFF);
    chk("ovr_noreq", 16'(nreq), 0);
    step(80);
    chk("ovr_sat", overrun_cnt, 8'hFF);
    pulse_done();
    step(16);
    chk("ovr_early", dac_req, 0);
    step(1);
    chk("ovr_req", dac_req, 1);
    chk("ovr_phase", dac_data, 8'h05);
    chk("ovr_cnt", sample_cnt, 1);

    // done coincides with the next tick (cycle 31)
    start(2, 16'h0100);
    step(13);
    i2c_done = 1;
    step(1);
    i2c_done = 0;
    chk("sim_busy", busy, 1);
    chk("sim_ovr", overrun_cnt, 0);
    step(2);
    chk("sim_req", dac_req, 1);
    chk("sim_data", dac_data, 8'h01);
    chk("sim_cnt", sample_cnt, 1);

    // enable dropped while waiting for done
    start(2, 16'h0100);
    enable = 0;
    step(5);
    pulse_done();
    chk("en_idle", busy, 0);
    nreq = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (dac_req || busy) nreq++;
    end
    chk("en_quiet", 16'(nreq), 0);
    enable = 1;
    step(17);
    chk("en_early", dac_req, 0);
    step(1);
    chk("en_req", dac_req, 1);
    chk("en_data", dac_data, 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
